// File: rtl/tentativa_scheduler_if.sv
// rtl/tentativa_scheduler_if.sv - board/checker signal bundle for the attempt scheduler
//
// Purpose: groups the button, switch, checker-verdict and scheduler output
// signals so they travel as one port.
// Ports (signals):
//   botao_n     raw insert button, active-low, asynchronous
//   numero      digit switches (0..9 valid)
//   ver_total   checker in total-success state
//   ver_parcial checker in partial-success state
//   ver_falha   checker in failure state
//   insere_n    one-cycle active-low strobe to the checker
//   digito      digit latched with the last accepted press
//   rst_checker one-cycle re-arm pulse to the checker
//   aberto      lock open
//   bloqueado   lockout active
//   tentativas  failed attempts since last clear
// Modports: master drives the board/checker side, slave is the scheduler.
interface tentativa_scheduler_if;
  logic       botao_n;
  logic [3:0] numero;
  logic       ver_total;
  logic       ver_parcial;
  logic       ver_falha;
  logic       insere_n;
  logic [3:0] digito;
  logic       rst_checker;
  logic       aberto;
  logic       bloqueado;
  logic [1:0] tentativas;

  modport master (
    output botao_n, numero, ver_total, ver_parcial, ver_falha,
    input  insere_n, digito, rst_checker, aberto, bloqueado, tentativas
  );

  modport slave (
    input  botao_n, numero, ver_total, ver_parcial, ver_falha,
    output insere_n, digito, rst_checker, aberto, bloqueado, tentativas
  );
endinterface

// File: rtl/tentativa_scheduler.sv
// rtl/tentativa_scheduler.sv - sequences the six-digit password checker with lockout
//
// Purpose: turns raw button presses into single checker strobes, latches the
// digit, acts on the checker verdict (open lock / count failure), enforces a
// timed lockout after MAX_TENTATIVAS failures and re-arms the checker.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset, clears all state
//   bus    tentativa_scheduler_if.slave (button, switches, verdicts, outputs)
module tentativa_scheduler #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int T_ABERTO       = 20,
  parameter int T_BLOQUEIO     = 50
) (
  input logic                  clk,
  input logic                  reset,
  tentativa_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    LIVRE, PULSO, ESPERA, ABERTO, FALHOU, BLOQUEIO, REINICIA
  } state_t;

  state_t     state, next_state;
  logic [7:0] timer;
  logic       sync1, sync2, hist, press;
  logic       insere_n_q, rst_checker_q, aberto_q, bloqueado_q;
  logic [3:0] digito_q;
  logic [1:0] tentativas_q;

  // Two-flop synchronizer plus edge history; the detected falling edge is
  // registered once more so the strobe lands three edges after first sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
      press <= 1'b0;
    end else begin
      sync1 <= bus.botao_n;
      sync2 <= sync1;
      hist  <= sync2;
      press <= hist & ~sync2;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LIVRE:    if (press && bus.numero <= 4'd9) next_state = PULSO;
      PULSO:    next_state = ESPERA;
      ESPERA: begin
        if (bus.ver_falha)                         next_state = FALHOU;
        else if (bus.ver_total || bus.ver_parcial) next_state = ABERTO;
        else                                       next_state = LIVRE;
      end
      ABERTO:   if (timer == 8'(T_ABERTO - 1)) next_state = REINICIA;
      // tentativas already holds the incremented count while in FALHOU
      FALHOU:   next_state = (tentativas_q == 2'(MAX_TENTATIVAS)) ? BLOQUEIO : REINICIA;
      BLOQUEIO: if (timer == 8'(T_BLOQUEIO - 1)) next_state = REINICIA;
      REINICIA: next_state = LIVRE;
      default:  next_state = LIVRE;
    endcase
  end

  // Outputs are registered from next_state so they align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LIVRE;
      timer         <= 8'd0;
      insere_n_q    <= 1'b1;
      rst_checker_q <= 1'b0;
      aberto_q      <= 1'b0;
      bloqueado_q   <= 1'b0;
      digito_q      <= 4'd0;
      tentativas_q  <= 2'd0;
    end else begin
      state         <= next_state;
      insere_n_q    <= (next_state != PULSO);
      rst_checker_q <= (next_state == REINICIA);
      aberto_q      <= (next_state == ABERTO);
      bloqueado_q   <= (next_state == BLOQUEIO);

      if (next_state != state)
        timer <= 8'd0;
      else if (state == ABERTO || state == BLOQUEIO)
        timer <= timer + 8'd1;

      if (state == LIVRE && next_state == PULSO)
        digito_q <= bus.numero;

      if (state == ESPERA && next_state == FALHOU)
        tentativas_q <= (tentativas_q == 2'd3) ? 2'd3 : tentativas_q + 2'd1;
      else if ((state == ESPERA && next_state == ABERTO) ||
               (state == BLOQUEIO && next_state == REINICIA))
        tentativas_q <= 2'd0;
    end
  end

  assign bus.insere_n    = insere_n_q;
  assign bus.rst_checker = rst_checker_q;
  assign bus.aberto      = aberto_q;
  assign bus.bloqueado   = bloqueado_q;
  assign bus.digito      = digito_q;
  assign bus.tentativas  = tentativas_q;

endmodule
